fft_stage_sequencer: RTL and testbench

Parametrised successor to the fixed-size AGU/arbitration control in the FFT top. It sequences a complete in-place radix-2 DIT FFT with run-time point size up to N_MAX. It generates read, twiddle and latency-matched write addresses, ping-pong bank selection, inter-stage pipeline drain and a start/busy/done handshake. It sits between the input/output modules and the RAM/twiddle ROM/BPU datapath.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_delay_line.sv | 35 +++
 rtl/fft_stage_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT stage sequencer and its datapath partners.
// The default transform size and BPU pipeline latency live here so both sides agree.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  localparam int unsigned N_MAX_DEFAULT    = 1024;
  localparam int unsigned PIPE_LAT_DEFAULT = 2;

  // Address width of an N_MAX-point buffer
  function automatic int unsigned fft_addr_w(input int unsigned n_max);
    return $clog2(n_max);
  endfunction

  // Width of a field that holds log2 of the transform size (0..LOG2_NMAX)
  function automatic int unsigned fft_cfg_w(input int unsigned n_max);
    return $clog2($clog2(n_max) + 1);
  endfunction

  // Width of a stage index (0..LOG2_NMAX-1)
  function automatic int unsigned fft_stage_w(input int unsigned n_max);
    return $clog2($clog2(n_max));
  endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Enable-gated shift register carrying a valid bit alongside a data word.
module fft_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: read/twiddle/write addressing, ping-pong banks, drain.
// Optional FFT_SEQ_INVERSE_EN: capture inverse on start and drive tw_conj with the reads.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter  int unsigned N_MAX     = N_MAX_DEFAULT,
  parameter  int unsigned PIPE_LAT  = PIPE_LAT_DEFAULT,
  localparam int unsigned LOG2_NMAX = fft_addr_w(N_MAX),
  localparam int unsigned CW        = fft_cfg_w(N_MAX),
  localparam int unsigned SW        = fft_stage_w(N_MAX),
  localparam int unsigned PW        = LOG2_NMAX - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CW-1:0]        log2n_cfg,
  input  logic                 hold,
  input  logic                 inverse,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [LOG2_NMAX-1:0] rd_addr1,
  output logic [LOG2_NMAX-1:0] rd_addr2,
  output logic [PW-1:0]        tw_addr,
  output logic                 tw_conj,
  output logic                 wr_en,
  output logic [LOG2_NMAX-1:0] wr_addr1,
  output logic [LOG2_NMAX-1:0] wr_addr2,
  output logic                 rd_bank,
  output logic                 result_bank,
  output logic [SW-1:0]        stage,
  output logic [PW-1:0]        pair_id
);

  localparam int unsigned LW = LOG2_NMAX;
  localparam int unsigned DW = $clog2(PIPE_LAT) + 1;

  fft_state_e        state_q;
  logic [CW-1:0]     log2n_q, log2n_c;
  logic [SW-1:0]     stage_q;
  logic [PW-1:0]     pair_q, last_pair_c;
  logic [DW-1:0]     drain_q;
  logic              bank_q;
  logic [LW-1:0]     half_c;
  logic              last_stage_c;
  logic              run_c;
  logic [LW-1:0]     span_c, off_c, rd1_c, rd2_c;
  logic [PW-1:0]     tw_c;
  logic [2*LW-1:0]   wr_data;

  // Clamp requested size into 1..LOG2_NMAX
  always_comb begin
    log2n_c = log2n_cfg;
    if (log2n_cfg == '0)
      log2n_c = CW'(1);
    else if (log2n_cfg > CW'(LW))
      log2n_c = CW'(LW);
  end

  assign half_c       = LW'(1) << (log2n_q - CW'(1));
  assign last_pair_c  = PW'(half_c - LW'(1));
  assign last_stage_c = (stage_q == SW'(log2n_q - CW'(1)));
  assign run_c        = (state_q == RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      log2n_q <= '0;
      stage_q <= '0;
      pair_q  <= '0;
      drain_q <= '0;
      bank_q  <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            log2n_q <= log2n_c;
            stage_q <= '0;
            pair_q  <= '0;
            bank_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (pair_q == last_pair_c) begin
            drain_q <= '0;
            state_q <= DRAIN;
          end else begin
            pair_q <= pair_q + PW'(1);
          end
        end
        DRAIN: begin
          if (drain_q == DW'(PIPE_LAT - 1)) begin
            bank_q <= ~bank_q;
            if (last_stage_c) begin
              state_q <= DONE;
            end else begin
              stage_q <= stage_q + SW'(1);
              pair_q  <= '0;
              state_q <= RUN;
            end
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        DONE: begin
          stage_q <= '0;
          pair_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Butterfly operand and twiddle addresses for (stage_q, pair_q)
  always_comb begin
    span_c = LW'(1) << stage_q;
    off_c  = LW'(pair_q) & (span_c - LW'(1));
    rd1_c  = ((LW'(pair_q) >> stage_q) << ({1'b0, stage_q} + (SW+1)'(1))) | off_c;
    rd2_c  = rd1_c + span_c;
    tw_c   = PW'(off_c << (SW'(LW - 1) - stage_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr1    <= '0;
      rd_addr2    <= '0;
      tw_addr     <= '0;
      stage       <= '0;
      pair_id     <= '0;
      rd_bank     <= 1'b0;
      result_bank <= 1'b0;
    end else if (!hold) begin
      busy     <= (state_q == RUN) || (state_q == DRAIN);
      done     <= (state_q == DONE);
      rd_en    <= run_c;
      rd_addr1 <= run_c ? rd1_c : '0;
      rd_addr2 <= run_c ? rd2_c : '0;
      tw_addr  <= run_c ? tw_c : '0;
      stage    <= stage_q;
      pair_id  <= pair_q;
      rd_bank  <= bank_q;
      if (state_q == DONE)
        result_bank <= log2n_q[0];
    end
  end

`ifdef FFT_SEQ_INVERSE_EN
  logic inv_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_q   <= 1'b0;
      tw_conj <= 1'b0;
    end else if (!hold) begin
      if ((state_q == IDLE) && start)
        inv_q <= inverse;
      tw_conj <= run_c & inv_q;
    end
  end
`else
  logic unused_inverse;

  assign unused_inverse = inverse;
  assign tw_conj        = 1'b0;
`endif

  // Write-back addresses follow the reads through the BPU latency
  fft_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (2 * LW)
  ) u_wr_dly (
    .clk       (clk),
    .reset     (reset),
    .en        (!hold),
    .in_valid  (rd_en),
    .in_data   ({rd_addr1, rd_addr2}),
    .out_valid (wr_en),
    .out_data  (wr_data)
  );

  assign {wr_addr1, wr_addr2} = wr_data;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer at N_MAX=32, PIPE_LAT=2 (FFT_SEQ_INVERSE_EN aware).
module tb_fft_stage_sequencer;

  localparam int unsigned N_MAX    = 32;
  localparam int unsigned PIPE_LAT = 2;
  localparam int unsigned LW       = 5;
  localparam int unsigned PW       = 4;
  localparam int unsigned CW       = 3;
  localparam int unsigned SW       = 3;
`ifdef FFT_SEQ_INVERSE_EN
  localparam int EXP_CONJ = 1;
`else
  localparam int EXP_CONJ = 0;
`endif

  logic          clk, reset, start, hold, inverse;
  logic [CW-1:0] log2n_cfg;
  logic          busy, done, rd_en, tw_conj, wr_en, rd_bank, result_bank;
  logic [LW-1:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2;
  logic [PW-1:0] tw_addr, pair_id;
  logic [SW-1:0] stage;

  fft_stage_sequencer #(.N_MAX(N_MAX), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .log2n_cfg(log2n_cfg), .hold(hold),
    .inverse(inverse), .busy(busy), .done(done), .rd_en(rd_en), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .tw_addr(tw_addr), .tw_conj(tw_conj), .wr_en(wr_en),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .rd_bank(rd_bank),
    .result_bank(result_bank), .stage(stage), .pair_id(pair_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Hand-derived 8-point schedule
  int exp_rd1  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_rd2  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw   [12] = '{0, 0, 0, 0, 0, 8, 0, 8, 0, 4, 8, 12};
  int exp_bank [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int exp_rdk  [12] = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};

  logic [63:0] c_rd1 [128], c_rd2 [128], c_tw [128], c_conj [128], c_bank [128], c_rdk [128];
  logic [63:0] c_wr1 [128], c_wr2 [128], c_wrk [128];
  logic [63:0] fz_rd1 [4], fz_rd2 [4], fz_tw [4], fz_rden [4], fz_wr1 [4], fz_wr2 [4];
  logic [63:0] fz_wren [4], fz_pair [4], fz_stage [4];
  int          n_rd, n_wr, n_fz, done_k;
  logic [63:0] busy_k1, busy_at_done, bank_at_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a transform and record every read/write beat until done or max_k cycles
  task automatic run_fft(input logic [CW-1:0] cfg, input logic inv, input int hold_k,
                         input int hold_len, input int max_k);
    int k;
    bit frozen;
    n_rd = 0; n_wr = 0; n_fz = 0; done_k = -1;
    busy_k1 = 'x; busy_at_done = 'x; bank_at_done = 'x;
    @(negedge clk);
    log2n_cfg = cfg; inverse = inv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done_k < 0 && k < max_k) begin
      if (k == hold_k) hold = 1'b1;
      if (k == hold_k + hold_len) hold = 1'b0;
      if (k == 5) inverse = 1'b0;
      @(negedge clk);
      k++;
      frozen = (hold_k >= 0) && (k > hold_k) && (k <= hold_k + hold_len);
      if (frozen) begin
        if (n_fz < 4) begin
          fz_rd1[n_fz] = 64'(rd_addr1); fz_rd2[n_fz] = 64'(rd_addr2);
          fz_tw[n_fz] = 64'(tw_addr); fz_rden[n_fz] = 64'(rd_en);
          fz_wr1[n_fz] = 64'(wr_addr1); fz_wr2[n_fz] = 64'(wr_addr2);
          fz_wren[n_fz] = 64'(wr_en); fz_pair[n_fz] = 64'(pair_id);
          fz_stage[n_fz] = 64'(stage);
        end
        n_fz++;
      end else begin
        if (k == 1) busy_k1 = 64'(busy);
        if (rd_en && n_rd < 128) begin
          c_rd1[n_rd] = 64'(rd_addr1); c_rd2[n_rd] = 64'(rd_addr2);
          c_tw[n_rd] = 64'(tw_addr); c_conj[n_rd] = 64'(tw_conj);
          c_bank[n_rd] = 64'(rd_bank); c_rdk[n_rd] = 64'(k);
          n_rd++;
        end
        if (wr_en && n_wr < 128) begin
          c_wr1[n_wr] = 64'(wr_addr1); c_wr2[n_wr] = 64'(wr_addr2); c_wrk[n_wr] = 64'(k);
          n_wr++;
        end
        if (done) begin
          done_k = k; busy_at_done = 64'(busy); bank_at_done = 64'(result_bank);
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic check_seq8(input bit timing);
    chk("n_rd_8pt", 64'(n_rd), 64'(12));
    chk("n_wr_8pt", 64'(n_wr), 64'(12));
    for (int i = 0; i < 12; i++) begin
      chk("rd_addr1", c_rd1[i], 64'(exp_rd1[i]));
      chk("rd_addr2", c_rd2[i], 64'(exp_rd2[i]));
      chk("tw_addr", c_tw[i], 64'(exp_tw[i]));
      chk("wr_addr1", c_wr1[i], 64'(exp_rd1[i]));
      chk("wr_addr2", c_wr2[i], 64'(exp_rd2[i]));
      if (timing) begin
        chk("rd_cycle", c_rdk[i], 64'(exp_rdk[i]));
        chk("wr_cycle", c_wrk[i], 64'(exp_rdk[i] + int'(PIPE_LAT)));
        chk("rd_bank", c_bank[i], 64'(exp_bank[i]));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; hold = 1'b0; inverse = 1'b0; log2n_cfg = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, rd_en, wr_en, rd_bank, result_bank, tw_conj, stage,
        pair_id, rd_addr1, rd_addr2, wr_addr1, wr_addr2, tw_addr}), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    // 8-point transform, inverse requested then dropped mid-run
    run_fft(3'd3, 1'b1, -1, 0, 60);
    chk("done_cycle_8pt", 64'(done_k), 64'(19));
    chk("busy_first_cycle", busy_k1, 64'(1));
    chk("busy_at_done", busy_at_done, 64'(0));
    chk("result_bank_8pt", bank_at_done, 64'(1));
    check_seq8(1'b1);
    for (int i = 0; i < 12; i++) chk("tw_conj", c_conj[i], 64'(EXP_CONJ));
    @(negedge clk);
    chk("done_single_pulse", 64'(done), 64'(0));
    chk("result_bank_held", 64'(result_bank), 64'(1));
    chk("rd_bank_final", 64'(rd_bank), 64'(1));

    // Three-cycle hold while stage 1 pair 2 is on the outputs
    run_fft(3'd3, 1'b0, 9, 3, 60);
    chk("done_cycle_hold", 64'(done_k), 64'(22));
    check_seq8(1'b0);
    chk("n_frozen", 64'(n_fz), 64'(3));
    for (int i = 0; i < 3; i++) begin
      chk("hold_rd_addr1", fz_rd1[i], 64'(4));
      chk("hold_rd_addr2", fz_rd2[i], 64'(6));
      chk("hold_tw_addr", fz_tw[i], 64'(0));
      chk("hold_rd_en", fz_rden[i], 64'(1));
      chk("hold_wr_addr1", fz_wr1[i], 64'(0));
      chk("hold_wr_addr2", fz_wr2[i], 64'(2));
      chk("hold_wr_en", fz_wren[i], 64'(1));
      chk("hold_pair_id", fz_pair[i], 64'(2));
      chk("hold_stage", fz_stage[i], 64'(1));
    end

    // Reset asserted in the second drain cycle of stage 1
    @(negedge clk);
    log2n_cfg = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_reset_rd_en", 64'(rd_en), 64'(0));
    chk("pre_reset_wr_en", 64'(wr_en), 64'(1));
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("midrun_reset_outputs", 64'({busy, done, rd_en, wr_en, rd_bank, result_bank, tw_conj,
        stage, pair_id, rd_addr1, rd_addr2, wr_addr1, wr_addr2, tw_addr}), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    run_fft(3'd3, 1'b0, -1, 0, 60);
    chk("done_cycle_after_reset", 64'(done_k), 64'(19));
    check_seq8(1'b1);

    // log2n_cfg=0 clamps to a 2-point transform
    run_fft(3'd0, 1'b0, -1, 0, 20);
    chk("done_cycle_cfg0", 64'(done_k), 64'(4));
    chk("n_rd_cfg0", 64'(n_rd), 64'(1));
    chk("rd_addr1_cfg0", c_rd1[0], 64'(0));
    chk("rd_addr2_cfg0", c_rd2[0], 64'(1));
    chk("tw_addr_cfg0", c_tw[0], 64'(0));
    chk("result_bank_cfg0", bank_at_done, 64'(1));

    // log2n_cfg=2: 4-point transform, even stage count ends in bank 0
    run_fft(3'd2, 1'b0, -1, 0, 30);
    chk("done_cycle_cfg2", 64'(done_k), 64'(9));
    chk("n_rd_cfg2", 64'(n_rd), 64'(4));
    chk("rd_addr2_cfg2_last", c_rd2[3], 64'(3));
    chk("tw_addr_cfg2_last", c_tw[3], 64'(8));
    chk("result_bank_cfg2", bank_at_done, 64'(0));

    // log2n_cfg=7 clamps to 5 (32-point)
    run_fft(3'd7, 1'b0, -1, 0, 150);
    chk("done_cycle_cfg7", 64'(done_k), 64'(91));
    chk("n_rd_cfg7", 64'(n_rd), 64'(80));
    chk("n_wr_cfg7", 64'(n_wr), 64'(80));
    chk("rd_addr1_s0_last", c_rd1[15], 64'(30));
    chk("rd_addr2_s0_last", c_rd2[15], 64'(31));
    chk("rd_cycle_s1_first", c_rdk[16], 64'(19));
    chk("rd_addr2_s1_first", c_rd2[16], 64'(2));
    chk("tw_addr_s1_p1", c_tw[17], 64'(8));
    chk("rd_addr1_s4_last", c_rd1[79], 64'(15));
    chk("rd_addr2_s4_last", c_rd2[79], 64'(31));
    chk("tw_addr_s4_last", c_tw[79], 64'(15));
    chk("result_bank_cfg7", bank_at_done, 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
